// File: rtl/aes_word_packer.sv
// aes_word_packer
//   Upstream stage of the AES256 core. A word FIFO buffers the 32-bit words
//   written over AXI. A collect/hold packer pops one word per clock into a
//   shift register until WORDS_PER_BLOCK words are present. It then presents
//   the block and holds it until the AES engine accepts it.
//
//   Optional build macro: PACKER_BYTE_SWAP_EN. When it is defined, each word
//   is byte-reversed as it enters the shift register. FIFO contents and
//   level are not affected by this macro.
//
// Ports
//   s00_axi_aclk     clock
//   s00_axi_aresetn  asynchronous active-low reset
//   flush            synchronous clear of FIFO, packer and overflow flag
//   in_data/valid    word input; in_ready = FIFO not full
//   out_data/valid   assembled block; the first accepted word is in the MSBs
//   out_ready        block accepted by the engine
//   level            number of words in the FIFO (words already in the packer are excluded)
//   overflow         sticky flag: a word was offered while the FIFO was full
module aes_word_packer #(
  parameter int DEPTH           = 8,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic                            flush,
  input  logic [31:0]                     in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [32*WORDS_PER_BLOCK-1:0]   out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(DEPTH+1)-1:0]      level,
  output logic                            overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(WORDS_PER_BLOCK + 1);
  localparam int BW = 32 * WORDS_PER_BLOCK;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(WORDS_PER_BLOCK - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   sreg;
  logic            push, pop;
  logic [31:0]     pop_word;

  function automatic logic [31:0] word_map(input logic [31:0] w);
`ifdef PACKER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // in_ready is based only on level, so a pop in the same cycle does not open a slot early.
  assign in_ready  = (level != FULL);
  assign push      = in_valid & in_ready;
  assign out_valid = (state_q == HOLD);
  assign out_data  = sreg;
  assign pop_word  = word_map(mem[rd_ptr]);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      COLLECT: begin
        if (level != '0) begin
          pop = 1'b1;
          if (cnt == LAST) state_d = HOLD;
        end
      end
      HOLD: if (out_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
    if (flush) state_d = COLLECT;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q  <= COLLECT;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
      sreg     <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        // out_data (sreg) is intentionally left stale; out_valid already drops.
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        cnt      <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
        if (in_valid && !in_ready) overflow <= 1'b1;
        if (pop) begin
          // Shifting (instead of slicing) keeps WORDS_PER_BLOCK == 1 legal.
          sreg <= (sreg << 32) | BW'(pop_word);
          cnt  <= cnt + 1'b1;
        end else if (state_q == HOLD && out_ready) begin
          cnt  <= '0;
        end
      end
    end
  end

  // Storage has no reset; only the pointers and level decide what is valid.
  always_ff @(posedge s00_axi_aclk) begin
    if (push && !flush) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_aes_word_packer.sv
// tb_aes_word_packer
//   Self-checking bench for aes_word_packer with DEPTH=8 and WORDS_PER_BLOCK=4.
//   The reference model uses a word queue and a packer queue, and its state
//   advances once per clock edge. Each cycle the bench compares all outputs
//   against the model. Directed tests cover the documented vectors, and a
//   randomized phase follows them.
module tb_aes_word_packer;
  localparam int DEPTH = 8;
  localparam int WPB   = 4;
  localparam int BW    = 32 * WPB;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] level;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  int nblk  = 0;

  logic [31:0] mq[$];
  logic [31:0] pq[$];
  bit          held;
  bit          ovf;

  always #5 clk = ~clk;

  aes_word_packer #(.DEPTH(DEPTH), .WORDS_PER_BLOCK(WPB)) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .flush          (flush),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .level          (level),
    .overflow       (overflow)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef PACKER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [255:0] exp_block();
    logic [BW-1:0] b = '0;
    foreach (pq[i]) b = (b << 32) | BW'(sw(pq[i]));
    return 256'(b);
  endfunction

  task automatic model_clear();
    mq.delete(); pq.delete(); held = 0; ovf = 0;
  endtask

  // Advances the model by one clock edge, using the inputs present at that edge.
  task automatic model_edge();
    bit acc;
    if (flush) begin
      model_clear();
      return;
    end
    acc = in_valid && (mq.size() < DEPTH);
    if (in_valid && mq.size() == DEPTH) ovf = 1;
    if (held) begin
      if (out_ready) begin held = 0; pq.delete(); end
    end else if (mq.size() > 0) begin
      pq.push_back(mq.pop_front());
      if (pq.size() == WPB) held = 1;
    end
    if (acc) mq.push_back(in_data);
  endtask

  task automatic check_all();
    chk("in_ready",  256'(in_ready),  256'(mq.size() < DEPTH));
    chk("out_valid", 256'(out_valid), 256'(held));
    chk("level",     256'(level),     256'(mq.size()));
    chk("overflow",  256'(overflow),  256'(ovf));
    if (held) chk("out_data", 256'(out_data), exp_block());
  endtask

  task automatic step();
    bit hs;
    hs = out_valid && out_ready;
    @(posedge clk);
    model_edge();
    if (hs) nblk++;
    #1;
    check_all();
  endtask

  // Holds the word until the DUT accepts it, for at most 100 cycles.
  task automatic send(input logic [31:0] w);
    bit acc = 0;
    in_valid = 1; in_data = w;
    for (int k = 0; k < 100 && !acc; k++) begin
      acc = in_ready;
      step();
    end
    if (!acc) chk("send_timeout", 256'(0), 256'(1));
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic reset_now();
    rst_n = 0;
    #1;
    model_clear();
    chk("rst_in_ready",  256'(in_ready),  256'(1));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_level",     256'(level),     256'(0));
    chk("rst_overflow",  256'(overflow),  256'(0));
    @(negedge clk);
    rst_n = 1;
  endtask

  logic [127:0] t2_exp;
  int nb0;

  initial begin
`ifdef PACKER_BYTE_SWAP_EN
    t2_exp = 128'h03020100070605040B0A09080F0E0D0C;
`else
    t2_exp = 128'h000102030405060708090A0B0C0D0E0F;
`endif
    rst_n = 0; flush = 0; in_data = '0; in_valid = 0; out_ready = 0;
    model_clear();
    #3;
    chk("rst_out_data", 256'(out_data), 256'(0));
    reset_now();

    // Reset partway through a block, then confirm the next block is clean.
    send(32'h11111111); send(32'h22222222); idle(1);
    reset_now();
    send(32'h01); send(32'h02); send(32'h03); send(32'h04); idle(2);
    chk("t1_block", 256'(out_data), 256'(128'h00000001000000020000000300000004));
    out_ready = 1; step(); out_ready = 0;

    // Basic block with the documented vectors.
    send(32'h00010203); send(32'h04050607); send(32'h08090A0B); send(32'h0C0D0E0F);
    step();
    chk("t2_valid", 256'(out_valid), 256'(1));
    chk("t2_data",  256'(out_data),  256'(t2_exp));
    chk("t2_level", 256'(level),     256'(0));
    out_ready = 1; step(); out_ready = 0;
    chk("t2_release", 256'(out_valid), 256'(0));

    // Fill the FIFO while the output is blocked, then overflow it.
    for (int i = 0; i < 12; i++) send(32'hC0DE0000 + i);
    chk("t3_level",    256'(level),    256'(8));
    chk("t3_in_ready", 256'(in_ready), 256'(0));
    in_valid = 1; in_data = 32'hDEAD0013; step(); in_valid = 0;
    chk("t3_overflow", 256'(overflow), 256'(1));
    nb0 = nblk; out_ready = 1; idle(20);
    chk("t3_blocks", 256'(nblk - nb0), 256'(3));
    chk("t3_drained", 256'(level), 256'(0));

    // Stream 40 words while out_ready stays high.
    nb0 = nblk;
    for (int i = 0; i < 40; i++) send(i);
    idle(16);
    chk("t4_blocks", 256'(nblk - nb0), 256'(10));

    // Flush with a partial block, then build a fresh block.
    out_ready = 0;
    send(32'h55555555); send(32'h66666666);
    flush = 1; step(); flush = 0;
    chk("t5_level",    256'(level),     256'(0));
    chk("t5_valid",    256'(out_valid), 256'(0));
    chk("t5_overflow", 256'(overflow),  256'(0));
    send(32'hAAAAAAAA); send(32'hBBBBBBBB); send(32'hAAAAAAAA); send(32'hBBBBBBBB);
    step();
    chk("t5_data", 256'(out_data), 256'(128'hAAAAAAAABBBBBBBBAAAAAAAABBBBBBBB));
    out_ready = 1; step();

    // Randomized traffic, with occasional flushes.
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(2) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(1) != 0);
      flush     = ($urandom_range(60) == 0);
      step();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
